// File: rtl/rob_multi.sv
// rob_multi: reorder buffer, 2-wide dispatch, N_EX completion ports, 2-wide in-order commit
module rob_multi #(
  parameter int ENTRY_NUM = 64,
  parameter int ENTRY_SEL = 6,
  parameter int REG_SEL   = 5,
  parameter int N_EX      = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush_i,
  input  logic                      dp1_i,
  input  logic                      dp2_i,
  input  logic [REG_SEL-1:0]        dst_dp1_i,
  input  logic [REG_SEL-1:0]        dst_dp2_i,
  input  logic                      dst_vld_dp1_i,
  input  logic                      dst_vld_dp2_i,
  output logic [ENTRY_SEL-1:0]      dp1_addr_o,
  output logic [ENTRY_SEL-1:0]      dp2_addr_o,
  output logic                      alloc_ok_o,
  input  logic [N_EX-1:0]           finish_ex_i,
  input  logic [N_EX*ENTRY_SEL-1:0] ex_addr_i,
  output logic [ENTRY_SEL-1:0]      commit_ptr_o,
  output logic                      arfwe_1_o,
  output logic [REG_SEL-1:0]        dst_arf_1_o,
  output logic                      arfwe_2_o,
  output logic [REG_SEL-1:0]        dst_arf_2_o,
  output logic [1:0]                comnum_o,
  output logic [ENTRY_SEL:0]        count_o,
  output logic                      empty_o
);
  localparam logic [ENTRY_SEL:0] alloc_lim = (ENTRY_SEL+1)'(ENTRY_NUM - 2);
  logic [ENTRY_SEL-1:0] head, tail, head1, tail1;
  logic [ENTRY_SEL:0]   count;
  logic [ENTRY_NUM-1:0] valid, finish, dst_vld;
  logic [REG_SEL-1:0]   dst [ENTRY_NUM];
  logic                 c1, c2;
  logic [1:0]           ndisp;
  always_comb begin
    head1        = head + 1'b1;
    tail1        = tail + 1'b1;
    c1           = valid[head] & finish[head];
    c2           = c1 & valid[head1] & finish[head1];
    alloc_ok_o   = count <= alloc_lim;
    ndisp        = (alloc_ok_o && dp1_i) ? (dp2_i ? 2'd2 : 2'd1) : 2'd0;
    arfwe_1_o    = !flush_i & c1 & dst_vld[head];
    arfwe_2_o    = !flush_i & c2 & dst_vld[head1];
    dst_arf_1_o  = dst[head];
    dst_arf_2_o  = dst[head1];
    comnum_o     = flush_i ? 2'd0 : {c2, c1 & ~c2};
    dp1_addr_o   = tail;
    dp2_addr_o   = tail1;
    commit_ptr_o = head;
    count_o      = count;
    empty_o      = count == '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      valid  <= '0;
      finish <= '0;
    end else if (flush_i) begin
      tail   <= head;
      count  <= '0;
      valid  <= '0;
      finish <= '0;
    end else begin
      // completions only land on entries that were already allocated
      for (int k = 0; k < N_EX; k++)
        if (finish_ex_i[k] && valid[ex_addr_i[k*ENTRY_SEL +: ENTRY_SEL]])
          finish[ex_addr_i[k*ENTRY_SEL +: ENTRY_SEL]] <= 1'b1;
      if (c1) valid[head] <= 1'b0;
      if (c2) valid[head1] <= 1'b0;
      // dispatch slots never alias retiring entries: tail != head unless empty
      if (ndisp != 2'd0) begin
        valid[tail]   <= 1'b1;
        finish[tail]  <= 1'b0;
        dst[tail]     <= dst_dp1_i;
        dst_vld[tail] <= dst_vld_dp1_i;
      end
      if (ndisp == 2'd2) begin
        valid[tail1]   <= 1'b1;
        finish[tail1]  <= 1'b0;
        dst[tail1]     <= dst_dp2_i;
        dst_vld[tail1] <= dst_vld_dp2_i;
      end
      head  <= head + ENTRY_SEL'(comnum_o);
      tail  <= tail + ENTRY_SEL'(ndisp);
      count <= count + (ENTRY_SEL+1)'(ndisp) - (ENTRY_SEL+1)'(comnum_o);
    end
  end
endmodule

// File: tb/tb_rob_multi.sv
// tb_rob_multi: randomized check of rob_multi against a program-order queue model
module tb_rob_multi;
  localparam int EN = 64, ES = 6, RS = 5, NX = 4;
  logic clk = 0, reset = 1, flush_i = 0, dp1_i = 0, dp2_i = 0;
  logic [RS-1:0] dst_dp1_i = 0, dst_dp2_i = 0;
  logic dst_vld_dp1_i = 0, dst_vld_dp2_i = 0;
  logic [ES-1:0] dp1_addr_o, dp2_addr_o, commit_ptr_o;
  logic alloc_ok_o, arfwe_1_o, arfwe_2_o, empty_o;
  logic [NX-1:0] finish_ex_i = 0;
  logic [NX*ES-1:0] ex_addr_i = 0;
  logic [RS-1:0] dst_arf_1_o, dst_arf_2_o;
  logic [1:0] comnum_o;
  logic [ES:0] count_o;

  rob_multi #(.ENTRY_NUM(EN), .ENTRY_SEL(ES), .REG_SEL(RS), .N_EX(NX)) dut (
    .clk(clk), .reset(reset), .flush_i(flush_i), .dp1_i(dp1_i), .dp2_i(dp2_i),
    .dst_dp1_i(dst_dp1_i), .dst_dp2_i(dst_dp2_i),
    .dst_vld_dp1_i(dst_vld_dp1_i), .dst_vld_dp2_i(dst_vld_dp2_i),
    .dp1_addr_o(dp1_addr_o), .dp2_addr_o(dp2_addr_o), .alloc_ok_o(alloc_ok_o),
    .finish_ex_i(finish_ex_i), .ex_addr_i(ex_addr_i), .commit_ptr_o(commit_ptr_o),
    .arfwe_1_o(arfwe_1_o), .dst_arf_1_o(dst_arf_1_o),
    .arfwe_2_o(arfwe_2_o), .dst_arf_2_o(dst_arf_2_o),
    .comnum_o(comnum_o), .count_o(count_o), .empty_o(empty_o));

  always #5 clk = ~clk;

  typedef struct {int idx; int dst; bit dv; bit fin;} ent_t;
  ent_t q[$];
  int head = 0;
  int n_cmp = 0, n_bad = 0;
  int n_full = 0, n_wrap2 = 0, n_flush = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  initial begin
    int addr[NX];
    int tail, sz, nd, com, phase, p_dp, p_ex;
    bit c1, c2, alloc;
    repeat (3) @(negedge clk);
    reset = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      phase = (cyc / 150) % 3;
      p_dp = phase == 0 ? 90 : phase == 1 ? 15 : 55;
      p_ex = phase == 0 ? 5 : phase == 1 ? 60 : 30;
      sz = q.size();
      if (cyc == 0) begin
        flush_i = 0; dp1_i = 0; dp2_i = 0; finish_ex_i = 0;
      end else begin
        flush_i = ($urandom % 100) < 1;
        dp1_i = ($urandom % 100) < p_dp;
        dp2_i = $urandom % 2;
        dst_dp1_i = RS'($urandom); dst_dp2_i = RS'($urandom);
        dst_vld_dp1_i = ($urandom % 4) != 0; dst_vld_dp2_i = ($urandom % 4) != 0;
        for (int k = 0; k < NX; k++) begin
          finish_ex_i[k] = ($urandom % 100) < p_ex;
          addr[k] = (sz > 0 && ($urandom % 5) != 0) ? q[$urandom_range(0, sz - 1)].idx
                                                    : int'($urandom % EN);
          ex_addr_i[k*ES +: ES] = ES'(addr[k]);
        end
      end
      #1;
      tail = (head + sz) % EN;
      alloc = (EN - sz) >= 2;
      c1 = sz >= 1 && q[0].fin;
      c2 = c1 && sz >= 2 && q[1].fin;
      com = flush_i ? 0 : int'(c1) + int'(c2);
      nd = (alloc && dp1_i) ? 1 + int'(dp2_i) : 0;
      chk("count", int'(count_o), sz);
      chk("empty", int'(empty_o), int'(sz == 0));
      chk("alloc_ok", int'(alloc_ok_o), int'(alloc));
      chk("commit_ptr", int'(commit_ptr_o), head);
      chk("dp1_addr", int'(dp1_addr_o), tail);
      chk("dp2_addr", int'(dp2_addr_o), (tail + 1) % EN);
      chk("comnum", int'(comnum_o), com);
      chk("arfwe_1", int'(arfwe_1_o), int'(!flush_i && c1 && q[0].dv));
      chk("arfwe_2", int'(arfwe_2_o), int'(!flush_i && c2 && q[1].dv));
      if (c1) chk("dst_arf_1", int'(dst_arf_1_o), q[0].dst);
      if (c2) chk("dst_arf_2", int'(dst_arf_2_o), q[1].dst);
      if (sz == EN) n_full++;
      if (com == 2 && head == EN - 1) n_wrap2++;
      if (flush_i) begin
        n_flush++;
        q.delete();
      end else begin
        for (int k = 0; k < NX; k++)
          if (finish_ex_i[k])
            foreach (q[i]) if (q[i].idx == addr[k]) q[i].fin = 1;
        repeat (com) void'(q.pop_front());
        head = (head + com) % EN;
        if (nd >= 1) q.push_back('{tail, int'(dst_dp1_i), dst_vld_dp1_i, 1'b0});
        if (nd == 2) q.push_back('{(tail + 1) % EN, int'(dst_dp2_i), dst_vld_dp2_i, 1'b0});
      end
    end
    chk("reached_full", int'(n_full > 0), 1);
    chk("dual_commit_wrap", int'(n_wrap2 > 0), 1);
    chk("saw_flush", int'(n_flush > 0), 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rob_multi.md
Name: rob_multi

Overview:
Parametrised reorder buffer for the out-of-order core. It owns its own allocation (tail) pointer and accepts up to 2 dispatches per cycle. It takes completions from N_EX execution ports and retires up to 2 finished instructions per cycle in program order, producing architectural-register write enables. A synchronous flush discards all in-flight entries.

Parameters:
ENTRY_NUM, 64, ROB depth; power of two, >=4
ENTRY_SEL, 6, log2(ENTRY_NUM); index width
REG_SEL, 5, architectural register index width
N_EX, 4, number of completion ports

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
flush_i  in  1  discard all entries
dp1_i  in  1  dispatch slot 1 valid
dp2_i  in  1  dispatch slot 2 valid; legal only with dp1_i
dst_dp1_i  in  REG_SEL  slot 1 destination register
dst_dp2_i  in  REG_SEL  slot 2 destination register
dst_vld_dp1_i  in  1  slot 1 writes a register
dst_vld_dp2_i  in  1  slot 2 writes a register
dp1_addr_o  out  ENTRY_SEL  entry index given to slot 1 (= tail)
dp2_addr_o  out  ENTRY_SEL  entry index given to slot 2 (= tail+1 mod ENTRY_NUM)
alloc_ok_o  out  1  at least 2 entries free
finish_ex_i  in  N_EX  per-port completion strobe
ex_addr_i  in  N_EX*ENTRY_SEL  packed completion indices; port k at [k*ENTRY_SEL +: ENTRY_SEL]
commit_ptr_o  out  ENTRY_SEL  head index (registered)
arfwe_1_o  out  1  commit slot 1 register write enable
dst_arf_1_o  out  REG_SEL  commit slot 1 destination register
arfwe_2_o  out  1  commit slot 2 register write enable
dst_arf_2_o  out  REG_SEL  commit slot 2 destination register
comnum_o  out  2  number of entries retired this cycle (0..2)
count_o  out  ENTRY_SEL+1  occupied entries
empty_o  out  1  count_o == 0

Behaviour:
- State: head, tail, count, plus per-entry valid, finish, dst and dst_vld.
- Reset (highest priority): head=0, tail=0, count=0, all valid/finish cleared. After reset: commit_ptr_o=0, count_o=0, empty_o=1, alloc_ok_o=1, all arfwe=0, comnum_o=0, dp1_addr_o=0, dp2_addr_o=1.
- Flush (priority below reset, above all else):
  - tail<=head, count<=0, valid and finish cleared.
  - Dispatches, completions and commits in the flush cycle are discarded.
  - Outputs in the flush cycle reflect pre-flush state, but arfwe_1_o/arfwe_2_o and comnum_o are forced to 0.
- alloc_ok_o = (ENTRY_NUM - count) >= 2; combinational from registered count.
- Accepted dispatch count ndisp:
  - 0 if !alloc_ok_o or !dp1_i; dispatches are dropped and tail is unchanged.
  - Otherwise 1 + dp2_i. dp2_i without dp1_i is ignored.
- On an accepted dispatch, each entry written sets valid=1, finish=0, and loads dst/dst_vld. tail <= (tail + ndisp) mod ENTRY_NUM.
- Completion: for each port k with finish_ex_i[k], set finish at that index only if valid=1; completions to invalid entries are ignored. Two ports hitting the same index is legal (idempotent).
- Commit (combinational from registered state):
  - c1 = valid[head] & finish[head].
  - c2 = c1 & valid[head+1] & finish[head+1], indices mod ENTRY_NUM.
  - arfwe_1_o = c1 & dst_vld[head]; arfwe_2_o = c2 & dst_vld[head+1].
  - dst_arf_1_o/dst_arf_2_o are always driven from dst[head]/dst[head+1].
  - comnum_o = c1 + c2.
  - Retired entries have valid cleared. head <= (head + comnum_o) mod ENTRY_NUM.
- count <= count + ndisp - comnum_o. alloc_ok_o uses pre-update count, so freed entries become allocatable next cycle.
- Latency:
  - Dispatch to earliest commit is 2 cycles: dispatch at cycle t, completion at t+1, commit visible at t+2.
  - A completion at cycle t is visible to commit at t+1. Same-cycle completion-to-commit bypass is not provided.
- Simultaneous events:
  - Dispatch into a slot freed by commit in the same cycle is impossible (tail != head unless empty).
  - When empty, head==tail. A dispatch that cycle writes the head entry; commit does not see it until the next cycle.
- Full: count==ENTRY_NUM means alloc_ok_o=0 and tail==head. No overwrite is possible.
- Wrap: pointers wrap silently at ENTRY_NUM-1 -> 0, including a dual dispatch or dual commit straddling the wrap.

Test Plan:
- Reset then idle -> commit_ptr_o=0, count_o=0, empty_o=1, alloc_ok_o=1, comnum_o=0, dp1_addr_o=0, dp2_addr_o=1.
- Dual dispatch dst 3/7 (both valid), complete index 1 then index 0 on later cycles -> no commit until index 0 finishes; then one cycle with arfwe_1_o=1/dst 3, arfwe_2_o=1/dst 7, comnum_o=2, commit_ptr_o=2.
- Fill 64 entries with 32 dual dispatches -> alloc_ok_o=0 at count 63 and 64. Dispatch with alloc_ok_o=0 -> dropped, tail unchanged, count_o stays 64.
- Entries 62,63,0,1 straddling wrap, all finished -> commits at heads 62 then 0 with comnum_o=2 each, commit_ptr_o wraps to 0 then 2.
- dst_vld=0 on slot 1, completion from ports 0 and 3 to the same index -> commit with arfwe_1_o=0, comnum_o=1. A completion to an invalid index leaves finish unchanged.
- 5 in-flight entries, flush_i with simultaneous dispatch and completion -> next cycle count_o=0, empty_o=1, dp1_addr_o=commit_ptr_o; no arfwe asserted in the flush cycle.
